// File: rtl/rx_sync_ctrl.sv
// rx_sync_ctrl: acquires and holds word sync on K28.5 commas and forwards decoded bytes while synced.
module rx_sync_ctrl #(
    parameter int COMMA_COUNT = 3,
    parameter int ERR_LIMIT   = 4,
    parameter int GOOD_RUN    = 4,
    parameter int ERRCNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sym_valid,
    input  logic [7:0]          data8_in,
    input  logic                k_in,
    input  logic                invalid_in,
    input  logic                err_clr,
    output logic [7:0]          data8_out,
    output logic                k_out,
    output logic                data_valid,
    output logic                sync_ok,
    output logic                sync_lost,
    output logic [ERRCNT_W-1:0] err_count
);
    localparam int CW = $clog2(COMMA_COUNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam int GW = $clog2(GOOD_RUN + 1);
    localparam logic [CW-1:0] COMMA_LAST = CW'(COMMA_COUNT - 1);
    localparam logic [EW-1:0] ERR_LAST   = EW'(ERR_LIMIT - 1);
    localparam logic [GW-1:0] GOOD_LAST  = GW'(GOOD_RUN - 1);

    typedef enum logic [1:0] {LOSS, ACQ, SYNC} state_t;

    state_t        state;
    logic [CW-1:0] comma_cnt;
    logic [EW-1:0] err_lvl;
    logic [GW-1:0] good_cnt;
    logic          comma;
    logic          fwd;

    assign comma = sym_valid & k_in & (data8_in == 8'hBC) & ~invalid_in;
    assign fwd   = sym_valid & (state == SYNC) & ~invalid_in;

    // Comparisons use the pre-increment value so counters never need an extra bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOSS;
            comma_cnt <= '0;
            err_lvl   <= '0;
            good_cnt  <= '0;
            sync_ok   <= 1'b0;
            sync_lost <= 1'b0;
        end else begin
            sync_lost <= 1'b0;
            if (sym_valid) begin
                case (state)
                    LOSS: if (comma) begin
                        state     <= ACQ;
                        comma_cnt <= CW'(1);
                    end
                    ACQ: if (invalid_in) begin
                        state     <= LOSS;
                        comma_cnt <= '0;
                    end else if (comma) begin
                        comma_cnt <= comma_cnt + CW'(1);
                        if (comma_cnt == COMMA_LAST) begin
                            state    <= SYNC;
                            sync_ok  <= 1'b1;
                            err_lvl  <= '0;
                            good_cnt <= '0;
                        end
                    end
                    SYNC: if (invalid_in) begin
                        good_cnt <= '0;
                        if (err_lvl == ERR_LAST) begin
                            state     <= LOSS;
                            sync_ok   <= 1'b0;
                            sync_lost <= 1'b1;
                            err_lvl   <= '0;
                            comma_cnt <= '0;
                        end else begin
                            err_lvl <= err_lvl + EW'(1);
                        end
                    end else if (good_cnt == GOOD_LAST) begin
                        good_cnt <= '0;
                        err_lvl  <= (err_lvl != '0) ? err_lvl - EW'(1) : err_lvl;
                    end else begin
                        good_cnt <= good_cnt + GW'(1);
                    end
                    default: state <= LOSS;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data8_out  <= 8'h00;
            k_out      <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= fwd;
            data8_out  <= fwd ? data8_in : data8_out;
            k_out      <= fwd ? k_in : k_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (sym_valid && invalid_in && !(&err_count)) begin
            err_count <= err_count + ERRCNT_W'(1);
        end
    end
endmodule

// File: tb/tb_rx_sync_ctrl.sv
// tb_rx_sync_ctrl: scoreboard bench comparing rx_sync_ctrl against a streak-counting reference model.
module tb_rx_sync_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sym_valid = 1'b0;
    logic [7:0] data8_in = 8'h00;
    logic       k_in = 1'b0;
    logic       invalid_in = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data8_out;
    logic       k_out, data_valid, sync_ok, sync_lost;
    logic [7:0] err_count;
    logic [7:0] s_data8_out;
    logic       s_k_out, s_data_valid, s_sync_ok, s_sync_lost;
    logic [1:0] s_err_count;

    rx_sync_ctrl u_dut (
        .clk(clk), .rst(rst), .sym_valid(sym_valid), .data8_in(data8_in), .k_in(k_in),
        .invalid_in(invalid_in), .err_clr(err_clr), .data8_out(data8_out), .k_out(k_out),
        .data_valid(data_valid), .sync_ok(sync_ok), .sync_lost(sync_lost), .err_count(err_count)
    );

    rx_sync_ctrl #(.ERRCNT_W(2)) u_small (
        .clk(clk), .rst(rst), .sym_valid(sym_valid), .data8_in(data8_in), .k_in(k_in),
        .invalid_in(invalid_in), .err_clr(err_clr), .data8_out(s_data8_out), .k_out(s_k_out),
        .data_valid(s_data_valid), .sync_ok(s_sync_ok), .sync_lost(s_sync_lost), .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [7:0] d;
        logic       k;
        logic       ok;
        logic       lost;
        logic [7:0] ec;
        logic [1:0] ecs;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    // Reference model: sync is a flag, acquisition is a streak of clean commas,
    // loss is an error level that good runs pay back.
    bit       m_sync;
    int       m_commas, m_errs, m_good, m_ec, m_ecs;
    bit [7:0] m_dout;
    bit       m_kout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("data_valid", 32'(data_valid), 32'(e.dv));
            check("data8_out", 32'(data8_out), 32'(e.d));
            check("k_out", 32'(k_out), 32'(e.k));
            check("sync_ok", 32'(sync_ok), 32'(e.ok));
            check("sync_lost", 32'(sync_lost), 32'(e.lost));
            check("err_count", 32'(err_count), 32'(e.ec));
            check("err_count_w2", 32'(s_err_count), 32'(e.ecs));
        end
    end

    task automatic push(input bit dv, input bit lost);
        exp_t x;
        x.dv = dv; x.d = m_dout; x.k = m_kout; x.ok = m_sync; x.lost = lost;
        x.ec = 8'(m_ec); x.ecs = 2'(m_ecs);
        q.push_back(x);
    endtask

    task automatic model_reset();
        m_sync = 0; m_commas = 0; m_errs = 0; m_good = 0; m_ec = 0; m_ecs = 0;
        m_dout = 8'h00; m_kout = 0;
        push(0, 0);
    endtask

    task automatic model_step(input bit sv, input bit [7:0] d, input bit k, input bit inv, input bit clr);
        bit dv = 0, lost = 0;
        if (clr) begin
            m_ec = 0; m_ecs = 0;
        end else if (sv && inv) begin
            m_ec = (m_ec == 255) ? 255 : m_ec + 1;
            m_ecs = (m_ecs == 3) ? 3 : m_ecs + 1;
        end
        if (sv) begin
            if (m_sync) begin
                if (inv) begin
                    m_errs++; m_good = 0;
                    if (m_errs == 4) begin
                        m_sync = 0; lost = 1; m_errs = 0; m_commas = 0;
                    end
                end else begin
                    dv = 1; m_dout = d; m_kout = k;
                    m_good++;
                    if (m_good == 4) begin
                        m_good = 0;
                        if (m_errs > 0) m_errs--;
                    end
                end
            end else if (inv) begin
                m_commas = 0;
            end else if (k && d == 8'hBC) begin
                m_commas++;
                if (m_commas == 3) begin
                    m_sync = 1; m_errs = 0; m_good = 0;
                end
            end
        end
        push(dv, lost);
    endtask

    task automatic drive(input bit sv, input bit [7:0] d, input bit k, input bit inv, input bit clr);
        @(negedge clk);
        rst = 1; sym_valid = sv; data8_in = d; k_in = k; invalid_in = inv; err_clr = clr;
        model_step(sv, d, k, inv, clr);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 0; sym_valid = 1'($urandom); data8_in = 8'($urandom); k_in = 1'($urandom);
            invalid_in = 1'($urandom); err_clr = 1'($urandom);
            model_reset();
        end
    endtask

    task automatic comma_sym();
        drive(1, 8'hBC, 1, 0, 0);
    endtask

    task automatic bad_sym(input bit clr);
        drive(1, 8'($urandom), 1'($urandom), 1, clr);
    endtask

    task automatic data_sym(input bit [7:0] d);
        drive(1, d, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 8'($urandom), 1'($urandom), 1'($urandom), 0);
    endtask

    initial begin
        do_reset(4);
        idle(3);
        repeat (3) comma_sym();
        data_sym(8'h4A);
        idle(2);
        repeat (4) bad_sym(0);
        idle(1);
        comma_sym(); comma_sym(); bad_sym(0); comma_sym(); comma_sym();
        idle(1);
        comma_sym();
        data_sym(8'h11);
        bad_sym(0);
        for (int i = 0; i < 4; i++) data_sym(8'(8'h20 + i));
        repeat (3) bad_sym(0);
        data_sym(8'h5C);
        drive(1, 8'hBC, 1, 0, 0);
        bad_sym(0);
        idle(1);
        do_reset(1);
        repeat (5) bad_sym(0);
        bad_sym(1);
        idle(1);
        repeat (260) bad_sym(0);
        drive(0, 8'h00, 0, 0, 1);
        for (int c = 0; c < 3000; c++) begin
            int r = $urandom_range(0, 99);
            bit clr = ($urandom_range(0, 99) < 3);
            if (c == 1500) do_reset(2);
            if (r < 15) drive(0, 8'($urandom), 1'($urandom), 1'($urandom), clr);
            else if (r < 50) drive(1, 8'hBC, 1, 0, clr);
            else if (r < 60) drive(1, 8'($urandom), 1'($urandom), 1, clr);
            else if (r < 65) drive(1, 8'hBC, 0, 0, clr);
            else drive(1, 8'($urandom), 1'($urandom), 0, clr);
        end
        idle(2);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
